// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: frame state
// encoding, the idle line level and a counter-width helper.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Width needed for a counter that must hold every value 0..max_count.
  function automatic int count_bits(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a first-word-fall-through FIFO and its drain.
// master: the drain stage that issues pops; slave: the FIFO that serves them.
interface fifo_uart_tx_if #(
  parameter int N = 8
);
  logic         fifo_empty;
  logic [N-1:0] fifo_rd_data;
  logic         fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of
// each serial bit. A synchronous clear restarts the period from zero.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = count_bits(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  // Cycle counter within the current bit; wraps at the end of every bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (!reset || clear || bit_end) cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO onto a UART line: start bit, N data
// bits LSB first, optional even parity, STOP_BITS stop bits. Frames run
// back-to-back while words are available and tx_enable is high.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds an even parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = count_bits(N);

  tx_state_e     state, state_d;
  logic [N-1:0]  shift, shift_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic          tx_d;
  logic          bit_end;
  logic          last_stop_cycle;
  logic          pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity;
`endif

  // Pops happen only between frames or in the very last cycle of a frame,
  // so the FIFO head is captured in the same cycle it is consumed.
  assign last_stop_cycle = (state == STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
  assign pop             = reset & tx_enable & ~fifo.fifo_empty &
                           ((state == IDLE) | last_stop_cycle);
  assign fifo.fifo_rd_en = pop;
  assign busy            = (state != IDLE);
  assign frame_done      = reset & last_stop_cycle;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == IDLE) | pop),
    .bit_end (bit_end)
  );

  // Next-state, shift register and next line level for the frame sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    tx_d      = tx;

    case (state)
      IDLE: tx_d = TX_IDLE_LEVEL;
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift[0];
        end
      end
      DATA: begin
        tx_d = shift[0];
        if (bit_end) begin
          if (bit_cnt == BW'(N - 1)) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity;
`else
            state_d   = STOP;
            tx_d      = TX_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            shift_d   = shift >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity;
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = TX_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        tx_d = TX_IDLE_LEVEL;
        if (bit_end) begin
          if (last_stop_cycle) state_d = IDLE;
          else                 bit_cnt_d = bit_cnt + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE_LEVEL;
      end
    endcase

    // A pop starts the next frame immediately, overriding the return to IDLE.
    if (pop) begin
      state_d   = START;
      shift_d   = fifo.fifo_rd_data;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end
  end

  // State, datapath and registered line output with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= TX_IDLE_LEVEL;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity of the word, computed once when it is popped.
  always_ff @(posedge clk) begin
    if (!reset)   parity <= 1'b0;
    else if (pop) parity <= ^fifo.fifo_rd_data;
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-based FIFO model. Honours
// FIFO_UART_TX_PARITY_EN to select 10- or 11-bit frame expectations.
module tb_fifo_uart_tx;

  localparam int N   = 8;
  localparam int CPB = 16;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P   = 1;
`else
  localparam int P   = 0;
`endif
  localparam int BITS   = 1 + N + P + SB;
  localparam int FLEN   = BITS * CPB;
  localparam int LOGMAX = 4 * FLEN;

  logic clk = 1'b0;
  logic reset;
  logic tx_enable;
  logic tx;
  logic busy;
  logic frame_done;

  fifo_uart_tx_if #(.N(N)) ifc ();

  fifo_uart_tx #(
    .N            (N),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo       (ifc.master),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  int         pop_cnt       = 0;
  int         underflow_cnt = 0;
  int         pass_cnt      = 0;
  int         check_cnt     = 0;
  logic       tx_log   [0:LOGMAX];
  logic       fd_log   [0:LOGMAX];
  logic       busy_log [0:LOGMAX];

  task automatic fifo_drive();
    ifc.fifo_empty   = (fifo_q.size() == 0);
    ifc.fifo_rd_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_drive();
  endtask

  // FIFO model: a pop strobe seen at the edge removes the head just after it.
  always @(posedge clk) begin
    if (ifc.fifo_rd_en === 1'b1) begin
      pop_cnt++;
      if (fifo_q.size() == 0) underflow_cnt++;
      #1;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_drive();
    end
  end

  // Expected line level in cycle c (1-based) of the frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int idx;
    idx = (c - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= N) return b[idx-1];
    if (P == 1 && idx == N + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic record(input int first, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tx_log[first+i]   = tx;
      fd_log[first+i]   = frame_done;
      busy_log[first+i] = busy;
    end
  endtask

  // Counts cycles in [first, first+FLEN) whose tx differs from byte b's frame.
  function automatic int frame_errs(input logic [7:0] b, input int first);
    int n;
    n = 0;
    for (int c = 1; c <= FLEN; c++)
      if (tx_log[first+c-1] !== exp_tx(b, c)) n++;
    return n;
  endfunction

  task automatic test_reset();
    int bad_rd, bad_tx, bad_busy, bad_fd;
    bad_rd = 0; bad_tx = 0; bad_busy = 0; bad_fd = 0;
    reset = 1'b0;
    tx_enable = 1'b1;
    push(8'h99);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ifc.fifo_rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1)             bad_tx++;
      if (busy !== 1'b0)           bad_busy++;
      if (frame_done !== 1'b0)     bad_fd++;
    end
    check_cnt++; if (bad_rd !== 0)   $display("FAIL reset_rd_en: %0d cycles high, want 0", bad_rd);     else pass_cnt++;
    check_cnt++; if (bad_tx !== 0)   $display("FAIL reset_tx: %0d cycles not 1, want 0", bad_tx);       else pass_cnt++;
    check_cnt++; if (bad_busy !== 0) $display("FAIL reset_busy: %0d cycles high, want 0", bad_busy);    else pass_cnt++;
    check_cnt++; if (bad_fd !== 0)   $display("FAIL reset_frame_done: %0d cycles high, want 0", bad_fd); else pass_cnt++;
    fifo_q.delete();
    fifo_drive();
    reset = 1'b1;
    @(negedge clk);
    check_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL post_reset_idle: tx=%b busy=%b, want tx=1 busy=0", tx, busy); else pass_cnt++;
    check_cnt++; if (pop_cnt !== 0) $display("FAIL reset_pops: got %0d, want 0", pop_cnt); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    int p0, bad, bad_busy, fd_sum, bad_seq;
`ifdef FIFO_UART_TX_PARITY_EN
    logic [BITS-1:0] a5_seq = 11'b10100101010;
`else
    logic [BITS-1:0] a5_seq = 10'b1101001010;
`endif
    p0 = pop_cnt;
    push(8'hA5);
    #1;
    check_cnt++; if (ifc.fifo_rd_en !== 1'b1) $display("FAIL a5_pop_strobe: rd_en=%b, want 1", ifc.fifo_rd_en); else pass_cnt++;
    record(1, FLEN + 1);
    bad = frame_errs(8'hA5, 1);
    check_cnt++; if (bad !== 0) $display("FAIL a5_bits: %0d bad cycles, want 0", bad); else pass_cnt++;
    bad_seq = 0;
    for (int i = 0; i < BITS; i++)
      if (tx_log[i*CPB + CPB/2] !== a5_seq[i]) bad_seq++;
    check_cnt++; if (bad_seq !== 0) $display("FAIL a5_sequence: %0d bits differ from hand vector", bad_seq); else pass_cnt++;
    bad_busy = 0; fd_sum = 0;
    for (int c = 1; c <= FLEN; c++) begin
      if (busy_log[c] !== 1'b1) bad_busy++;
      if (fd_log[c] === 1'b1) fd_sum++;
    end
    check_cnt++; if (bad_busy !== 0) $display("FAIL a5_busy: %0d cycles low, want 0", bad_busy); else pass_cnt++;
    check_cnt++; if (fd_sum !== 1 || fd_log[FLEN] !== 1'b1) $display("FAIL a5_frame_done: count=%0d last=%b, want 1 at cycle %0d", fd_sum, fd_log[FLEN], FLEN); else pass_cnt++;
    check_cnt++; if (tx_log[FLEN+1] !== 1'b1 || busy_log[FLEN+1] !== 1'b0) $display("FAIL a5_idle_after: tx=%b busy=%b, want 1/0", tx_log[FLEN+1], busy_log[FLEN+1]); else pass_cnt++;
    check_cnt++; if (pop_cnt - p0 !== 1) $display("FAIL a5_pops: got %0d, want 1", pop_cnt - p0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int p0, bad_busy, bad_tail, fd_sum;
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h3C};
    p0 = pop_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    record(1, 3*FLEN + CPB);
    for (int f = 0; f < 3; f++) begin
      int bad;
      bad = frame_errs(words[f], 1 + f*FLEN);
      check_cnt++; if (bad !== 0) $display("FAIL b2b_frame%0d_bits: %0d bad cycles, want 0", f, bad); else pass_cnt++;
    end
    bad_busy = 0; fd_sum = 0; bad_tail = 0;
    for (int c = 1; c <= 3*FLEN; c++) begin
      if (busy_log[c] !== 1'b1) bad_busy++;
      if (fd_log[c] === 1'b1) fd_sum++;
    end
    for (int c = 3*FLEN + 1; c <= 3*FLEN + CPB; c++)
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) bad_tail++;
    check_cnt++; if (bad_busy !== 0) $display("FAIL b2b_gap: busy low %0d cycles, want 0", bad_busy); else pass_cnt++;
    check_cnt++; if (fd_sum !== 3 || fd_log[2*FLEN] !== 1'b1) $display("FAIL b2b_frame_done: count=%0d, want 3", fd_sum); else pass_cnt++;
    check_cnt++; if (bad_tail !== 0) $display("FAIL b2b_idle_after: %0d bad cycles, want 0", bad_tail); else pass_cnt++;
    check_cnt++; if (pop_cnt - p0 !== 3) $display("FAIL b2b_pops: got %0d, want 3", pop_cnt - p0); else pass_cnt++;
  endtask

  task automatic test_tx_enable();
    int p0, bad, bad_hold;
    p0 = pop_cnt;
    push(8'h55); push(8'h66);
    record(1, 40);
    tx_enable = 1'b0;
    record(41, FLEN - 40 + 30);
    bad = frame_errs(8'h55, 1);
    check_cnt++; if (bad !== 0) $display("FAIL txen_55_bits: %0d bad cycles, want 0", bad); else pass_cnt++;
    bad_hold = 0;
    for (int c = FLEN + 1; c <= FLEN + 30; c++)
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) bad_hold++;
    check_cnt++; if (bad_hold !== 0) $display("FAIL txen_hold_idle: %0d bad cycles, want 0", bad_hold); else pass_cnt++;
    check_cnt++; if (pop_cnt - p0 !== 1 || fifo_q.size() !== 1) $display("FAIL txen_no_pop: pops=%0d depth=%0d, want 1/1", pop_cnt - p0, fifo_q.size()); else pass_cnt++;
    tx_enable = 1'b1;
    #1;
    check_cnt++; if (ifc.fifo_rd_en !== 1'b1) $display("FAIL txen_resume_pop: rd_en=%b, want 1", ifc.fifo_rd_en); else pass_cnt++;
    record(1, FLEN);
    check_cnt++; if (tx_log[1] !== 1'b0 || busy_log[1] !== 1'b1) $display("FAIL txen_resume_start: tx=%b busy=%b, want 0/1", tx_log[1], busy_log[1]); else pass_cnt++;
    bad = frame_errs(8'h66, 1);
    check_cnt++; if (bad !== 0) $display("FAIL txen_66_bits: %0d bad cycles, want 0", bad); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int p0, bad;
    p0 = pop_cnt;
    push(8'h81); push(8'h42);
    record(1, 70);
    reset = 1'b0;
    @(negedge clk);
    check_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL abort_line: tx=%b busy=%b, want 1/0", tx, busy); else pass_cnt++;
    check_cnt++; if (ifc.fifo_rd_en !== 1'b0) $display("FAIL abort_rd_en: rd_en=%b, want 0", ifc.fifo_rd_en); else pass_cnt++;
    check_cnt++; if (pop_cnt - p0 !== 1 || fifo_q.size() !== 1 || fifo_q[0] !== 8'h42) $display("FAIL abort_fifo: pops=%0d depth=%0d, want 1/1 head 42", pop_cnt - p0, fifo_q.size()); else pass_cnt++;
    reset = 1'b1;
    record(1, FLEN + 1);
    bad = frame_errs(8'h42, 1);
    check_cnt++; if (bad !== 0) $display("FAIL abort_next_bits: %0d bad cycles, want 0", bad); else pass_cnt++;
    check_cnt++; if (pop_cnt - p0 !== 2 || tx_log[FLEN+1] !== 1'b1) $display("FAIL abort_next_pops: pops=%0d tx=%b, want 2/1", pop_cnt - p0, tx_log[FLEN+1]); else pass_cnt++;
  endtask

  task automatic test_parity();
    int bad0, bad1;
    push(8'h07); push(8'h03);
    record(1, 2*FLEN + CPB);
    bad0 = frame_errs(8'h07, 1);
    bad1 = frame_errs(8'h03, 1 + FLEN);
    check_cnt++; if (bad0 !== 0) $display("FAIL par_07_bits: %0d bad cycles, want 0", bad0); else pass_cnt++;
    check_cnt++; if (bad1 !== 0) $display("FAIL par_03_bits: %0d bad cycles, want 0", bad1); else pass_cnt++;
`ifdef FIFO_UART_TX_PARITY_EN
    check_cnt++; if (tx_log[9*CPB + 8] !== 1'b1) $display("FAIL par_07_bit: got %b, want 1", tx_log[9*CPB + 8]); else pass_cnt++;
    check_cnt++; if (tx_log[FLEN + 9*CPB + 8] !== 1'b0) $display("FAIL par_03_bit: got %b, want 0", tx_log[FLEN + 9*CPB + 8]); else pass_cnt++;
    check_cnt++; if (fd_log[176] !== 1'b1 || fd_log[160] !== 1'b0) $display("FAIL par_len: done@160=%b done@176=%b, want 0/1", fd_log[160], fd_log[176]); else pass_cnt++;
`else
    check_cnt++; if (fd_log[160] !== 1'b1 || tx_log[161] !== 1'b0) $display("FAIL nopar_len: done@160=%b tx@161=%b, want 1/0", fd_log[160], tx_log[161]); else pass_cnt++;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_drive();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_tx_enable();
    test_reset_mid_frame();
    test_parity();
    check_cnt++; if (underflow_cnt !== 0) $display("FAIL underflow: %0d pops while empty, want 0", underflow_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
